// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sample streamer.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } sfx_state_t;

    localparam int SFX_ADDR_WIDTH    = 13;
    localparam int SFX_DATA_WIDTH    = 16;
    localparam int DINO_JUMP_SAMPLES = 5000;

endpackage

// File: rtl/sfx_sample_streamer.sv
// Walks an external 1-cycle-latency effect ROM and presents each (optionally
// attenuated) sample on a valid/ready stream, one sample per 3 cycles at best.
module sfx_sample_streamer
    import sfx_pkg::*;
#(
    parameter int ADDR_WIDTH   = SFX_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SFX_DATA_WIDTH,
    parameter int SAMPLE_COUNT = DINO_JUMP_SAMPLES,
    parameter int ATTEN_SHIFT  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_readdata,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SAMPLE_COUNT - 1);

    sfx_state_t            state, state_n;
    logic [ADDR_WIDTH-1:0] index, index_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  done_n;
    logic                  pending, pending_n;
    logic signed [DATA_WIDTH-1:0] atten;
    logic                  handshake;

    assign atten     = $signed(rom_readdata) >>> ATTEN_SHIFT;
    assign handshake = sample_valid && sample_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            rom_address  <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            pending      <= 1'b0;
        end else begin
            state        <= state_n;
            index        <= index_n;
            rom_address  <= addr_n;
            sample_data  <= data_n;
            sample_valid <= valid_n;
            done         <= done_n;
            pending      <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        index_n   = index;
        addr_n    = rom_address;
        data_n    = sample_data;
        valid_n   = sample_valid;
        done_n    = 1'b0;
        pending_n = pending;

        // stop outranks play everywhere; in IDLE it simply suppresses a start
        if (stop && state != IDLE) begin
            state_n   = IDLE;
            valid_n   = 1'b0;
            pending_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (play && !stop) begin
                        state_n   = FETCH;
                        index_n   = '0;
                        addr_n    = '0;
                        pending_n = 1'b0;
                    end
                end
                FETCH: begin
                    if (play) begin
                        index_n = '0;
                        addr_n  = '0;
                    end else begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (play) begin
                        state_n = FETCH;
                        index_n = '0;
                        addr_n  = '0;
                    end else begin
                        state_n = PRESENT;
                        data_n  = atten;
                        valid_n = 1'b1;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        valid_n = 1'b0;
                        // a restart requested while holding takes priority over termination
                        if (pending || play) begin
                            state_n   = FETCH;
                            index_n   = '0;
                            addr_n    = '0;
                            pending_n = 1'b0;
                        end else if (index == LAST_IDX) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = FETCH;
                            index_n = index + ADDR_WIDTH'(1);
                            addr_n  = rom_address + ADDR_WIDTH'(1);
                        end
                    end else if (play) begin
                        pending_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_sample_streamer.sv
// Directed bench: two streamers (no shift / shift by 2) share stimulus; a
// scoreboard queue per instance holds the samples each must deliver.
module tb_sfx_sample_streamer;

    localparam int AW = 13;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset, play, stop, sample_ready;

    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] rd_a, rd_b, data_a, data_b;
    logic          valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    logic [DW-1:0] rom_a [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [DW-1:0] rom_b [4] = '{16'h8000, 16'h7FFC, 16'h0004, 16'hFFFF};
    logic [DW-1:0] exp_a [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [DW-1:0] exp_b [4] = '{16'hE000, 16'h1FFF, 16'h0001, 16'hFFFF};

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    int compared   = 0;
    int mismatched = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int base_a, base_b;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_a <= rom_a[addr_a[1:0]];
        rd_b <= rom_b[addr_b[1:0]];
    end

    sfx_sample_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SAMPLE_COUNT(4), .ATTEN_SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .play(play), .stop(stop),
        .rom_address(addr_a), .rom_readdata(rd_a),
        .sample_data(data_a), .sample_valid(valid_a), .sample_ready(sample_ready),
        .busy(busy_a), .done(done_a)
    );

    sfx_sample_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SAMPLE_COUNT(4), .ATTEN_SHIFT(2)) dut_b (
        .clk(clk), .reset(reset), .play(play), .stop(stop),
        .rom_address(addr_b), .rom_readdata(rd_b),
        .sample_data(data_b), .sample_valid(valid_b), .sample_ready(sample_ready),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_idx(input int i);
        qa.push_back(exp_a[i]);
        qb.push_back(exp_b[i]);
    endtask

    task automatic push_all();
        for (int i = 0; i < 4; i++) push_idx(i);
    endtask

    // Handshakes are judged just before the edge, using the inputs the DUT will see.
    task automatic step();
        if (!reset && valid_a && sample_ready) begin
            if (qa.size() == 0) begin
                compared++; mismatched++;
                $error("FAIL unexpected_sample_a: observed %0h expected none", data_a);
            end else chk("sample_a", data_a, qa.pop_front());
        end
        if (!reset && valid_b && sample_ready) begin
            if (qb.size() == 0) begin
                compared++; mismatched++;
                $error("FAIL unexpected_sample_b: observed %0h expected none", data_b);
            end else chk("sample_b", data_b, qb.pop_front());
        end
        @(posedge clk);
        #1;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_busy_at_done"}, busy_a, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  addr_a,  0);
        chk({tag, "_data"},  data_a,  0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_busy"},  busy_a,  0);
        chk({tag, "_done"},  done_a,  0);
        chk({tag, "_data_b"}, data_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; play = 1'b0; stop = 1'b0; sample_ready = 1'b1;
        repeat (3) step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // 1: full playback, ready always high, 3-cycle cadence
        base_a = done_cnt_a; base_b = done_cnt_b;
        push_all();
        play = 1'b1; step(); play = 1'b0;
        chk("s1_busy_fetch", busy_a, 1);
        chk("s1_valid_fetch", valid_a, 0);
        step(); chk("s1_valid_wait", valid_a, 0);
        step(); chk("s1_first_valid", valid_a, 1);
        chk("s1_first_data_b", data_b, 16'hE000);
        for (int k = 1; k < 4; k++) begin
            step(); chk("s1_gap1_valid", valid_a, 0);
            step(); chk("s1_gap2_valid", valid_a, 0);
            step(); chk("s1_valid", valid_a, 1);
            chk("s1_addr", addr_a, k);
        end
        wait_done("s1", 10);
        step();
        chk("s1_done_single", done_a, 0);
        chk("s1_done_count", done_cnt_a - base_a, 1);
        chk("s1_done_count_b", done_cnt_b - base_b, 1);
        chk("s1_queue_a_empty", qa.size(), 0);
        chk("s1_queue_b_empty", qb.size(), 0);

        // 2: backpressure holds the first sample for 10 cycles
        push_all();
        play = 1'b1; step(); play = 1'b0;
        step(); step();
        sample_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s2_hold_valid", valid_a, 1);
            chk("s2_hold_data", data_a, 16'h1000);
            chk("s2_hold_addr", addr_a, 0);
        end
        sample_ready = 1'b1;
        step();
        chk("s2_valid_drop", valid_a, 0);
        chk("s2_addr_advance", addr_a, 1);
        wait_done("s2", 40);
        chk("s2_queue_a_empty", qa.size(), 0);

        // 4: play while holding sample at index 2 restarts after delivery, no done
        base_a = done_cnt_a;
        push_idx(0); push_idx(1); push_idx(2);
        play = 1'b1; step(); play = 1'b0;
        repeat (2) step();
        repeat (6) step();
        chk("s4_at_idx2_valid", valid_a, 1);
        chk("s4_at_idx2_addr", addr_a, 2);
        sample_ready = 1'b0;
        play = 1'b1; step(); play = 1'b0;
        step();
        chk("s4_still_holding", valid_a, 1);
        push_all();
        sample_ready = 1'b1;
        step();
        chk("s4_restart_addr", addr_a, 0);
        chk("s4_restart_busy", busy_a, 1);
        chk("s4_no_done", done_a, 0);
        wait_done("s4", 40);
        chk("s4_done_count", done_cnt_a - base_a, 1);
        chk("s4_queue_a_empty", qa.size(), 0);
        chk("s4_queue_b_empty", qb.size(), 0);

        // 5: stop in WAIT, play+stop together, stop while idle
        base_a = done_cnt_a;
        play = 1'b1; step(); play = 1'b0;
        step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("s5_stop_busy", busy_a, 0);
        chk("s5_stop_valid", valid_a, 0);
        chk("s5_stop_done", done_a, 0);
        play = 1'b1; step(); play = 1'b0;
        chk("s5_busy_fetch", busy_a, 1);
        play = 1'b1; stop = 1'b1; step(); play = 1'b0; stop = 1'b0;
        chk("s5_play_stop_busy", busy_a, 0);
        play = 1'b1; stop = 1'b1; step(); play = 1'b0; stop = 1'b0;
        chk("s5_idle_play_stop_busy", busy_a, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("s5_idle_stop_busy", busy_a, 0);
        repeat (4) step();
        chk("s5_no_done_count", done_cnt_a - base_a, 0);

        // 6: reset in PRESENT, then clean replay
        sample_ready = 1'b0;
        play = 1'b1; step(); play = 1'b0;
        step(); step();
        chk("s6_present_valid", valid_a, 1);
        reset = 1'b1; step();
        chk_reset_outputs("s6_reset");
        reset = 1'b0; sample_ready = 1'b1;
        base_a = done_cnt_a;
        push_all();
        play = 1'b1; step(); play = 1'b0;
        chk("s6_restart_addr", addr_a, 0);
        chk("s6_restart_busy", busy_a, 1);
        wait_done("s6", 40);
        chk("s6_done_count", done_cnt_a - base_a, 1);
        chk("s6_queue_a_empty", qa.size(), 0);
        chk("s6_queue_b_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sfx_sample_streamer.md
Name: sfx_sample_streamer

Overview:
Playback sequencer directly upstream of the dino-jump sound-effect ROM. It drives the ROM address, absorbs the ROM's 1-cycle synchronous read latency, optionally attenuates each sample, and presents it on a valid/ready stream toward the audio mixer/codec FIFO. One streamer instance serves one effect ROM. Playback starts on a single-cycle play request.

Parameters:
ADDR_WIDTH, 13, ROM address width; must match the attached ROM.
DATA_WIDTH, 16, sample width; samples are signed two's complement.
SAMPLE_COUNT, 5000, number of valid samples in the ROM image; legal range 1..2^ADDR_WIDTH.
ATTEN_SHIFT, 0, arithmetic right shift applied to every sample; legal range 0..DATA_WIDTH-1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
play  in  1  single-cycle request to start or restart the effect from sample 0.
stop  in  1  single-cycle request to abort playback.
rom_address  out  ADDR_WIDTH  registered address to the ROM.
rom_readdata  in  DATA_WIDTH  ROM data, valid one cycle after the address is presented.
sample_data  out  DATA_WIDTH  registered, attenuated sample.
sample_valid  out  1  sample_data is valid.
sample_ready  in  1  downstream accepts the sample when sample_valid && sample_ready.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset values: state IDLE; rom_address 0; sample_data 0; sample_valid 0; busy 0; done 0; index 0; pending-restart 0. Reset overrides everything, including mid-playback.
- States and transitions:
  - IDLE: play -> FETCH with rom_address=0 and index=0.
  - FETCH: rom_address is stable; the ROM latches it at the end of this cycle. Next state WAIT.
  - WAIT: rom_readdata is valid. Capture sample_data = rom_readdata >>> ATTEN_SHIFT (sign-preserving). Next state PRESENT with sample_valid=1.
  - PRESENT: hold sample_data and sample_valid until the handshake. On the handshake, sample_valid drops in the next cycle.
    - If index == SAMPLE_COUNT-1: go to IDLE and pulse done for one cycle.
    - Otherwise: increment index and rom_address, then go to FETCH.
- Minimum cadence: one sample per 3 cycles. Latency from play to first sample_valid: 3 cycles.
- A play in FETCH or WAIT restarts immediately: next state FETCH, address 0, index 0.
- A play in PRESENT sets pending-restart. The held sample is still delivered. On its handshake the block restarts at FETCH/address 0 and does not pulse done, even if the held sample was the last one.
- A stop in any non-IDLE state goes to IDLE on the next cycle. sample_valid clears without a handshake, pending-restart clears, and done does not pulse.
- play and stop asserted in the same cycle: stop wins.
- A stop in IDLE is ignored.
- busy = (state != IDLE). The done pulse coincides with the first IDLE cycle.
- rom_address wraps by width only. It never exceeds SAMPLE_COUNT-1 because of the termination rule.
- sample_ready held high continuously still yields the 3-cycle cadence. There are no back-to-back valids.

Decomposition:
- Shared package sfx_pkg holds:
  - the state enum typedef sfx_state_t (IDLE, FETCH, WAIT, PRESENT);
  - the constant SFX_ADDR_WIDTH = 13;
  - the constant SFX_DATA_WIDTH = 16;
  - the constant DINO_JUMP_SAMPLES = 5000.
- No sub-module: the ROM stays external, and the attenuator is a single expression. The bench instantiates the streamer together with the jump ROM, or a behavioural 1-cycle-latency model of it.

Test Plan:
1. Reset, then play with sample_ready=1 and SAMPLE_COUNT=4, ROM words 0x1000, 0x2000, 0x3000, 0x4000 -> first valid 3 cycles after play. Exactly these 4 samples arrive in order, 3 cycles apart. done pulses once, in the cycle after the 4th handshake. busy falls at the same time.
2. Backpressure: hold sample_ready=0 for 10 cycles in PRESENT -> sample_data and sample_valid are stable and rom_address does not change. The sample is accepted once ready rises.
3. ATTEN_SHIFT=2 with ROM word 0x8000 -> sample_data=0xE000. With ROM word 0x7FFC -> 0x1FFF.
4. play during PRESENT at index 2 -> the held sample is delivered, then the next sample is from address 0. There is no done pulse.
5. stop during WAIT -> IDLE next cycle, sample_valid=0, busy=0, no done. A simultaneous play+stop also gives IDLE.
6. Reset asserted in PRESENT with sample_valid=1 -> the next cycle shows all outputs at their reset values. A subsequent play restarts cleanly from address 0.
